// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] I_EXEC    = 4'd8;
  localparam logic [3:0] I_WB      = 4'd9;
  localparam logic [3:0] BRANCH    = 4'd10;
  localparam logic [3:0] JUMP      = 4'd11;
  localparam logic [3:0] HALT      = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_IMM,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - classifies the IR opcode and picks the I-type ALU operation
module mc_opcode_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic [5:0]   OpCode,
  output instr_class_t instr_class,
  output logic [2:0]   imm_alu_op,
  output logic         legal
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    imm_alu_op  = ALU_ADD;
    case (OpCode)
      OP_R:    instr_class = CLS_R;
      OP_LW:   instr_class = CLS_LW;
      OP_SW:   instr_class = CLS_SW;
      OP_BEQ:  instr_class = CLS_BEQ;
      OP_ADDI: instr_class = CLS_IMM;
      OP_SLTI: begin instr_class = CLS_IMM; imm_alu_op = ALU_SLT; end
      OP_ANDI: begin instr_class = CLS_IMM; imm_alu_op = ALU_AND; end
      OP_ORI:  begin instr_class = CLS_IMM; imm_alu_op = ALU_OR;  end
      OP_J:    if (ENABLE_JUMP) instr_class = CLS_J;
      default: ;
    endcase
    legal = (instr_class != CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing MIPS instructions over the multi-cycle datapath
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit ENABLE_JUMP     = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b0,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [2:0]       ALUOp,
  output logic             illegal_op,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy;
  logic             retire;
  instr_class_t     instr_class;
  logic [2:0]       imm_alu_op;
  logic             legal;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  mc_opcode_decode #(.ENABLE_JUMP(ENABLE_JUMP)) u_decode (
    .OpCode      (OpCode),
    .instr_class (instr_class),
    .imm_alu_op  (imm_alu_op),
    .legal       (legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH:     if (rdy) state_d = DECODE;
      DECODE: begin
        case (instr_class)
          CLS_LW, CLS_SW: state_d = MEM_ADDR;
          CLS_R:          state_d = R_EXEC;
          CLS_BEQ:        state_d = BRANCH;
          CLS_J:          state_d = JUMP;
          CLS_IMM:        state_d = I_EXEC;
          default:        state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
        endcase
      end
      MEM_ADDR:  state_d = (instr_class == CLS_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (rdy) state_d = MEM_WB;
      MEM_WRITE: if (rdy) begin state_d = FETCH; retire = 1'b1; end
      R_EXEC:    state_d = R_WB;
      I_EXEC:    state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Reset gates every control line so no datapath write can happen while it is held.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALU_ADD;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = rdy;
          PCWrite = rdy;
        end
        DECODE: begin
          ALUSrcB    = SRCB_IMM_SH2;
          illegal_op = !legal;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_RTYPE;
        end
        R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = imm_alu_op;
        end
        I_WB:    RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven bench for multicycle_control
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  // Control bundle bit order:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemToReg,IRWrite,RegWrite,RegDst,ALUSrcA}_ALUSrcB_PCSource_ALUOp_illegal_halted
  localparam logic [18:0] C_ZERO  = 19'b0000000000_00_00_000_0_0;
  localparam logic [18:0] C_FR    = 19'b1001001000_01_00_000_0_0;
  localparam logic [18:0] C_FW    = 19'b0001000000_01_00_000_0_0;
  localparam logic [18:0] C_DEC   = 19'b0000000000_11_00_000_0_0;
  localparam logic [18:0] C_DECI  = 19'b0000000000_11_00_000_1_0;
  localparam logic [18:0] C_MADDR = 19'b0000000001_10_00_000_0_0;
  localparam logic [18:0] C_MRD   = 19'b0011000000_00_00_000_0_0;
  localparam logic [18:0] C_MWB   = 19'b0000010100_00_00_000_0_0;
  localparam logic [18:0] C_MWR   = 19'b0010100000_00_00_000_0_0;
  localparam logic [18:0] C_REX   = 19'b0000000001_00_00_010_0_0;
  localparam logic [18:0] C_RWB   = 19'b0000000110_00_00_000_0_0;
  localparam logic [18:0] C_IADD  = 19'b0000000001_10_00_000_0_0;
  localparam logic [18:0] C_ISLT  = 19'b0000000001_10_00_111_0_0;
  localparam logic [18:0] C_IAND  = 19'b0000000001_10_00_100_0_0;
  localparam logic [18:0] C_IOR   = 19'b0000000001_10_00_110_0_0;
  localparam logic [18:0] C_IWB   = 19'b0000000100_00_00_000_0_0;
  localparam logic [18:0] C_BR    = 19'b0100000001_00_01_001_0_0;
  localparam logic [18:0] C_JMP   = 19'b1000000000_00_10_000_0_0;
  localparam logic [18:0] C_HALT  = 19'b0000000000_00_00_000_0_1;
  localparam logic [5:0]  OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic        rst = 1'b1, mem_ready = 1'b1;
  logic [5:0]  OpCode = OP_ADDI;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        illegal_op, halted;
  logic [3:0]  state;
  logic [15:0] instr_count;
  logic [18:0] ctl;

  multicycle_control dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .halted(halted), .state(state),
    .instr_count(instr_count)
  );
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite,
                RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op, halted};

  // Halting, no-jump, no-handshake instance with a 3-bit counter for the wrap test.
  logic        rst_h = 1'b1, mem_ready_h = 1'b0;
  logic [5:0]  op_h = OP_J;
  logic        pcw_h, pcwc_h, iord_h, mr_h, mw_h, mtr_h, irw_h, rw_h, rd_h, sa_h;
  logic [1:0]  sb_h, ps_h;
  logic [2:0]  aop_h;
  logic        ill_h, halted_h;
  logic [3:0]  state_h;
  logic [2:0]  cnt_h;
  logic [18:0] ctl_h;

  multicycle_control #(
    .MEM_HANDSHAKE(1'b0), .ENABLE_JUMP(1'b0), .HALT_ON_ILLEGAL(1'b1), .CNT_W(3)
  ) dut_h (
    .clk(clk), .rst(rst_h), .OpCode(op_h), .mem_ready(mem_ready_h),
    .PCWrite(pcw_h), .PCWriteCond(pcwc_h), .IorD(iord_h), .MemRead(mr_h),
    .MemWrite(mw_h), .MemToReg(mtr_h), .IRWrite(irw_h), .RegWrite(rw_h),
    .RegDst(rd_h), .ALUSrcA(sa_h), .ALUSrcB(sb_h), .PCSource(ps_h),
    .ALUOp(aop_h), .illegal_op(ill_h), .halted(halted_h), .state(state_h),
    .instr_count(cnt_h)
  );
  assign ctl_h = {pcw_h, pcwc_h, iord_h, mr_h, mw_h, mtr_h, irw_h, rw_h,
                  rd_h, sa_h, sb_h, ps_h, aop_h, ill_h, halted_h};

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] c;
    logic [15:0] n;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] c, input logic [15:0] n);
    vec_t v;
    v.r = r; v.op = op; v.rdy = rdy; v.st = st; v.c = c; v.n = n;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step_h(input int idx, input logic r, input logic [5:0] op,
                        input logic [3:0] st, input logic [18:0] c, input logic [2:0] n);
    @(negedge clk);
    rst_h = r; op_h = op;
    #1;
    check("h_state", idx, 32'(state_h), 32'(st));
    check("h_ctl", idx, 32'(ctl_h), 32'(c));
    check("h_count", idx, 32'(cnt_h), 32'(n));
  endtask

  initial begin
    // reset + addi
    add(1, OP_ADDI, 1, FETCH,  C_ZERO, 0);
    add(0, OP_ADDI, 1, FETCH,  C_FR,   0);
    add(0, OP_ADDI, 1, DECODE, C_DEC,  0);
    add(0, OP_ADDI, 1, I_EXEC, C_IADD, 0);
    add(0, OP_ADDI, 1, I_WB,   C_IWB,  0);
    // lw: 2 fetch waits (opcode garbage during one), 3 read waits -> 10 cycles
    add(0, OP_LW,   0, FETCH,    C_FW,    1);
    add(0, OP_BAD,  0, FETCH,    C_FW,    1);
    add(0, OP_LW,   1, FETCH,    C_FR,    1);
    add(0, OP_LW,   1, DECODE,   C_DEC,   1);
    add(0, OP_LW,   1, MEM_ADDR, C_MADDR, 1);
    add(0, OP_LW,   0, MEM_READ, C_MRD,   1);
    add(0, OP_LW,   0, MEM_READ, C_MRD,   1);
    add(0, OP_LW,   0, MEM_READ, C_MRD,   1);
    add(0, OP_LW,   1, MEM_READ, C_MRD,   1);
    add(0, OP_LW,   1, MEM_WB,   C_MWB,   1);
    // sw, beq, j back to back
    add(0, OP_SW,   1, FETCH,     C_FR,    2);
    add(0, OP_SW,   1, DECODE,    C_DEC,   2);
    add(0, OP_SW,   1, MEM_ADDR,  C_MADDR, 2);
    add(0, OP_SW,   1, MEM_WRITE, C_MWR,   2);
    add(0, OP_BEQ,  1, FETCH,     C_FR,    3);
    add(0, OP_BEQ,  1, DECODE,    C_DEC,   3);
    add(0, OP_BEQ,  1, BRANCH,    C_BR,    3);
    add(0, OP_J,    1, FETCH,     C_FR,    4);
    add(0, OP_J,    1, DECODE,    C_DEC,   4);
    add(0, OP_J,    1, JUMP,      C_JMP,   4);
    // R-type
    add(0, OP_R,    1, FETCH,  C_FR,  5);
    add(0, OP_R,    1, DECODE, C_DEC, 5);
    add(0, OP_R,    1, R_EXEC, C_REX, 5);
    add(0, OP_R,    1, R_WB,   C_RWB, 5);
    // illegal opcode returns to FETCH without retiring
    add(0, OP_BAD,  1, FETCH,  C_FR,   6);
    add(0, OP_BAD,  1, DECODE, C_DECI, 6);
    // slti, andi, ori
    add(0, OP_SLTI, 1, FETCH,  C_FR,   6);
    add(0, OP_SLTI, 1, DECODE, C_DEC,  6);
    add(0, OP_SLTI, 1, I_EXEC, C_ISLT, 6);
    add(0, OP_SLTI, 1, I_WB,   C_IWB,  6);
    add(0, OP_ANDI, 1, FETCH,  C_FR,   7);
    add(0, OP_ANDI, 1, DECODE, C_DEC,  7);
    add(0, OP_ANDI, 1, I_EXEC, C_IAND, 7);
    add(0, OP_ANDI, 1, I_WB,   C_IWB,  7);
    add(0, OP_ORI,  1, FETCH,  C_FR,   8);
    add(0, OP_ORI,  1, DECODE, C_DEC,  8);
    add(0, OP_ORI,  1, I_EXEC, C_IOR,  8);
    add(0, OP_ORI,  1, I_WB,   C_IWB,  8);
    // sw with one write wait
    add(0, OP_SW,   1, FETCH,     C_FR,    9);
    add(0, OP_SW,   1, DECODE,    C_DEC,   9);
    add(0, OP_SW,   1, MEM_ADDR,  C_MADDR, 9);
    add(0, OP_SW,   0, MEM_WRITE, C_MWR,   9);
    add(0, OP_SW,   1, MEM_WRITE, C_MWR,   9);
    // reset during a MEM_READ wait abandons the lw
    add(0, OP_LW,   1, FETCH,    C_FR,    10);
    add(0, OP_LW,   1, DECODE,   C_DEC,   10);
    add(0, OP_LW,   1, MEM_ADDR, C_MADDR, 10);
    add(0, OP_LW,   0, MEM_READ, C_MRD,   10);
    add(1, OP_LW,   0, MEM_READ, C_ZERO,  10);
    add(0, OP_LW,   1, FETCH,    C_FR,    0);

    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r; OpCode = vq[i].op; mem_ready = vq[i].rdy;
      #1;
      check("state", i, 32'(state), 32'(vq[i].st));
      check("ctl", i, 32'(ctl), 32'(vq[i].c));
      check("count", i, 32'(instr_count), 32'(vq[i].n));
    end

    // Halting instance: j is illegal here, mem_ready is ignored (held low).
    step_h(0, 0, OP_J,   FETCH,  C_FR,   0);
    step_h(1, 0, OP_J,   DECODE, C_DECI, 0);
    step_h(2, 0, OP_BEQ, HALT,   C_HALT, 0);
    step_h(3, 0, OP_BEQ, HALT,   C_HALT, 0);
    step_h(4, 0, OP_BEQ, HALT,   C_HALT, 0);
    step_h(5, 1, OP_BEQ, HALT,   C_ZERO, 0);
    step_h(6, 0, OP_BEQ, FETCH,  C_FR,   0);
    // Eight beq retirements wrap the 3-bit counter 7 -> 0.
    for (int k = 0; k < 8; k++) begin
      step_h(7 + 3*k, 0, OP_BEQ, DECODE, C_DEC, 3'(k));
      step_h(8 + 3*k, 0, OP_BEQ, BRANCH, C_BR,  3'(k));
      step_h(9 + 3*k, 0, OP_BEQ, FETCH,  C_FR,  (k == 7) ? 3'd0 : 3'(k + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle opcode decoder: a Moore-style FSM that sequences each MIPS instruction over 3–5 cycles (plus memory wait states) and drives the multi-cycle datapath control lines. It sits between the instruction register's `OpCode` field and the shared-memory/ALU/register-file datapath. It adds a shared-memory ready handshake, an optional `j` instruction, configurable handling of illegal opcodes, and a retired-instruction counter.

## Interface
- `MEM_HANDSHAKE`, 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` is ignored and treated as 1.
- `ENABLE_JUMP`, 1: 1 = opcode 000010 (`j`) is legal.
- `HALT_ON_ILLEGAL`, 0: 1 = an illegal opcode sends the FSM to HALT until reset; 0 = it returns to FETCH.
- `CNT_W`, 16: width of `instr_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `OpCode` in 6: `IR[31:26]`, stable from DECODE onward.
- `mem_ready` in 1: memory completes the access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemToReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1 each.
- `ALUSrcB` out 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp` out 3: 000 add, 001 sub, 010 R-type (funct), 100 and, 110 or, 111 slt.
- `illegal_op` out 1: one-cycle pulse in DECODE when the opcode is unrecognised.
- `halted` out 1: FSM is in HALT.
- `state` out 4: current state, for debug.
- `instr_count` out CNT_W: number of retired instructions; wraps.

## Operation
- Legal opcodes:
  - 000000 R
  - 000100 beq
  - 100011 lw
  - 101011 sw
  - 001000 addi
  - 001010 slti
  - 001100 andi
  - 001101 ori
  - 000010 j, only when ENABLE_JUMP = 1
- Outputs not listed for a state are 0.
- FETCH:
  - Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 000, PCSource = 00.
  - IRWrite and PCWrite are both equal to `mem_ready`.
  - Goes to DECODE on ready; otherwise stays in FETCH.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 000 (branch target goes to ALUOut). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → R_EXEC
  - beq → BRANCH
  - j → JUMP
  - addi/slti/andi/ori → I_EXEC
  - illegal → FETCH, or HALT if HALT_ON_ILLEGAL = 1
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 000. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead = 1, IorD = 1. Goes to MEM_WB on ready; otherwise waits.
- MEM_WB: RegWrite = 1, MemToReg = 1, RegDst = 0. Goes to FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1. Goes to FETCH on ready; otherwise waits.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 010. Goes to R_WB.
- R_WB: RegWrite = 1, RegDst = 1. Goes to FETCH.
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10. ALUOp is addi 000, slti 111, andi 100, ori 110. Goes to I_WB.
- I_WB: RegWrite = 1, RegDst = 0, MemToReg = 0. Goes to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 001, PCWriteCond = 1, PCSource = 01. Goes to FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Goes to FETCH.
- HALT: all control outputs are 0 and `halted` = 1. Only `rst` leaves HALT.
- Retire: `instr_count` increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH or JUMP. It does not increment on an illegal-opcode exit. It wraps from 2^CNT_W − 1 to 0.

## Timing
- Reset:
  - An edge with `rst` = 1 sets state = FETCH and `instr_count` = 0.
  - While `rst` = 1, every control output, `illegal_op` and `halted` is forced to 0 combinationally, so no write occurs during reset.
- Reset has priority over every transition, including a wait state and HALT. A reset asserted mid-instruction abandons that instruction, which does not retire.
- Latency with zero wait states:
  - lw: 5 cycles
  - sw, R, I-type: 4 cycles
  - beq, j: 3 cycles
- Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- IRWrite and PCWrite pulse only in the ready cycle, so the IR and PC update exactly once per fetch.
- `OpCode` is sampled only in DECODE and later; an `OpCode` change during FETCH has no effect.
- All other outputs are decoded from the registered state only (Moore).

## Structure
- Shared package/include `mc_ctrl_pkg`:
  - state encoding: 4-bit localparams FETCH = 0 … HALT = 12
  - opcode constants
  - ALUOp constants
  - ALUSrcB and PCSource encodings
- Sub-module `mc_opcode_decode` (combinational): `OpCode` → instruction class, immediate ALUOp, `legal` flag. Honours ENABLE_JUMP.
- Top level holds the state register, next-state logic, output decode and retire counter.

## Test plan
- `rst` for 2 cycles, then release with `mem_ready` = 1 and an `addi` opcode:
  - states go FETCH → DECODE → I_EXEC → I_WB → FETCH
  - RegWrite = 1 only in I_WB
  - `instr_count` = 1
- `lw` with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM_READ:
  - completes in 10 cycles
  - IRWrite is high for exactly 1 cycle
  - MemToReg = 1 in MEM_WB
- `sw`, `beq`, `j` back-to-back with ready tied high:
  - 4 + 3 + 3 cycles
  - MemWrite = 1 only in MEM_WRITE
  - PCWriteCond = 1 in BRANCH
  - PCSource = 10 in JUMP
  - `instr_count` advances by 3
- Opcode 111111:
  - with HALT_ON_ILLEGAL = 0: `illegal_op` pulses, the next state is FETCH, and the count does not change
  - with HALT_ON_ILLEGAL = 1: `halted` = 1 until `rst`
- `rst` asserted during a MEM_READ wait: the next state is FETCH, all outputs are 0 during reset, and `instr_count` = 0.
- Preload `instr_count` to 0xFFFF (CNT_W = 16) by running 65535 R-type instructions (or force in sim), then retire one more instruction: `instr_count` = 0.
